// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage register: DEPTH-entry in-order buffer with valid/ready
// on both sides, synchronous flush and a saturating back-pressure counter.
module pipe_stage_buf #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 2,
  parameter int READY_BYPASS = 1
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [31:0]                stall_cycles
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PW-1:0]               wr_ptr, rd_ptr;
  logic                        full, push, pop;

  // Explicit wrap so non-power-of-two depths cycle correctly.
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + PW'(1);
  endfunction

  assign full      = (count == CW'(DEPTH));
  assign in_ready  = (READY_BYPASS != 0) ? (!full || out_ready) : !full;
  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)     mem <= '0;
    else if (push) mem[wr_ptr] <= in_data;
  end

  // When full with a pop, wr_ptr == rd_ptr, so the new word lands in the slot being vacated.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wrap_inc(wr_ptr);
      if (pop)  rd_ptr <= wrap_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      stall_cycles <= '0;
    else if (out_valid && !out_ready && !flush && (stall_cycles != '1))
      stall_cycles <= stall_cycles + 32'd1;
  end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Parametrised elastic pipeline-stage register that replaces fixed IF/ID, ID/EX, EX/MEM and MEM/WB latches.
- Carries any packed stage struct as a flat WIDTH-bit word.
- Provides a DEPTH-entry in-order buffer with a valid/ready handshake on both sides, a synchronous flush for branch/jump squash, and a saturating back-pressure cycle counter for performance debug.
- Sits between two adjacent datapath stages; the hazard unit drives flush, and downstream stall appears as out_ready low.

Parameters:
- WIDTH, 32, bit width of the stage payload; a packed struct is cast to and from this width; must be at least 1.
- DEPTH, 2, number of buffered entries; must be at least 1.
- READY_BYPASS, 1, 1 means in_ready also asserts when full and the head is being consumed this cycle (combinational out_ready to in_ready path); 0 means in_ready depends only on registered state.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- flush  in  1  synchronous squash of all buffered entries.
- in_valid  in  1  upstream presents in_data.
- in_ready  out  1  stage can accept in_data this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream consumes the head this cycle.
- out_data  out  WIDTH  head entry payload.
- count  out  $clog2(DEPTH+1)  number of occupied entries.
- stall_cycles  out  32  saturating count of cycles with out_valid=1 and out_ready=0.

Behaviour:
- Reset (nRST low, asynchronous): count=0, read/write pointers=0, all storage=0, stall_cycles=0. Outputs: out_valid=0, out_data=0, in_ready=1.
- Definitions:
  - push = in_valid & in_ready & !flush.
  - pop = out_valid & out_ready & !flush.
- Storage: circular array of DEPTH entries.
  - On push, write in_data at wr_ptr, then wr_ptr = wr_ptr+1, wrapping from DEPTH-1 to 0.
  - On pop, rd_ptr = rd_ptr+1 with the same wrap.
  - Wrap is explicit and must work for non-power-of-two DEPTH.
- count: next = count + push - pop. Simultaneous push and pop leave count unchanged.
- out_valid = (count != 0). out_data = storage[rd_ptr] when count != 0, else 0.
- Latency: data pushed in cycle t appears on out_data in cycle t+1 at the earliest. There is no combinational in_data to out_data path.
- in_ready:
  - READY_BYPASS=1: in_ready = (count < DEPTH) | out_ready.
  - READY_BYPASS=0: in_ready = (count < DEPTH).
  - in_ready does not depend on flush.
- Full with pop (READY_BYPASS=1): push and pop occur in the same edge. The new entry is written into the slot being vacated (wr_ptr == rd_ptr); count stays at DEPTH.
- Empty with in_valid: no flow-through. out_valid stays 0 this cycle and becomes 1 the next cycle.
- flush:
  - At the edge: count=0 and wr_ptr=rd_ptr=0. Storage contents need not be cleared, but out_data must read 0 while empty.
  - flush wins over a simultaneous push or pop. The in_data offered that cycle is discarded, even if in_ready=1 and in_valid=1.
  - Upstream treats a flush cycle as not accepted.
- stall_cycles: increments when out_valid & !out_ready & !flush. Holds at 0xFFFFFFFF once reached. Unaffected by flush; cleared only by reset.
- out_ready while empty has no effect. in_valid while full (and no bypass) has no effect.
- Input stability: upstream holds in_data stable while in_valid=1 and in_ready=0. The stage does not check this.
- Reset asserted mid-transfer: all state is dropped immediately, asynchronously. The first edge after nRST rises behaves as a cycle in the empty state.

Test Plan (WIDTH=32, DEPTH=2, READY_BYPASS=1 unless stated):
- Reset then idle:
  - Stimulus: nRST pulse, then in_valid=0.
  - Required: out_valid=0, out_data=0, count=0, in_ready=1, stall_cycles=0 for 5 cycles.
- Back-pressure fill:
  - Stimulus: out_ready=0; push 0xAAAA0001, then 0xAAAA0002.
  - Required:
    - count reaches 2.
    - in_ready=0 with out_ready=0.
    - out_data=0xAAAA0001 throughout.
    - stall_cycles increments once per cycle from the cycle after the first push.
  - Then: raise out_ready for 2 cycles; out_data shows 0xAAAA0001, then 0xAAAA0002, then out_valid=0.
- Full bypass:
  - Stimulus: buffer full (0x1, 0x2); out_ready=1 and in_valid=1 with 0x3 in the same cycle.
  - Required: in_ready=1, count stays 2, next head=0x2, then 0x3; pointer wrap verified.
- Flush priority:
  - Stimulus: 2 entries held; assert flush with in_valid=1 (0xDEAD) and out_ready=1.
  - Required: next cycle count=0, out_valid=0, out_data=0; 0xDEAD never appears; stall_cycles is unchanged.
- READY_BYPASS=0, DEPTH=3:
  - Stimulus: stream 10 words continuously with out_ready=1.
  - Required: one word out per cycle after 1-cycle latency, in order, with no loss.
  - Then: with buffer full and out_ready=1, in_ready=0 in that cycle.
- Async reset mid-stream:
  - Stimulus: drop nRST between clock edges while count=2.
  - Required: out_valid=0, count=0 and stall_cycles=0 immediately, before the next edge.
